tcm_port_arbiter: RTL and testbench

//  Shares the single read/write port of the tightly-coupled instruction memory between two requesters.
//   - Requester 0: core load/store path (issues in MEMPREP, consumes data in MEMEX).
//   - Requester 1: debug/program loader.

---
 rtl/tcm_port_arbiter_if.sv | 44 ++++
 rtl/tcm_port_arbiter.sv | 132 +++++++++++++
 tb/tb_tcm_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the instruction TCM port arbiter.
// The arbiter uses the slave modport; the environment (requesters plus memory) uses master.
interface tcm_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic              core_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              dbg_owned;
  logic [31:0]       rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_stall,
    output dbg_gnt, dbg_rvalid, dbg_owned,
    output rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_stall,
    input  dbg_gnt, dbg_rvalid, dbg_owned,
    input  rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Shares the single rw port of the instruction TCM between the core load/store path and the
// debug loader: fixed core priority, bounded loader starvation, exclusive loader lock mode.
module tcm_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  tcm_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_SHARED = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [7:0] LIMIT_C   = 8'(STARVE_LIMIT);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] starve_r;
  logic [7:0] starve_nxt_s;
  logic       core_gnt_s;
  logic       dbg_gnt_s;
  logic       core_rvalid_r;
  logic       dbg_rvalid_r;

  // Grant selection: at most one requester owns the port in any cycle.
  always_comb begin
    core_gnt_s = 1'b0;
    dbg_gnt_s  = 1'b0;
    case (state_r)
      ST_SHARED: begin
        if (bus.dbg_req && (!bus.core_req || (starve_r >= LIMIT_C))) begin
          dbg_gnt_s = 1'b1;
        end else begin
          core_gnt_s = bus.core_req;
        end
      end
      ST_DRAIN: begin
        core_gnt_s = 1'b0;
        dbg_gnt_s  = 1'b0;
      end
      ST_LOCKED: begin
        dbg_gnt_s = bus.dbg_req;
      end
      default: begin
        core_gnt_s = 1'b0;
        dbg_gnt_s  = 1'b0;
      end
    endcase
  end

  // Memory port steering from the granted requester; idle port is driven to zero.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = 32'd0;
    if (core_gnt_s) begin
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (dbg_gnt_s) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end else begin
      bus.mem_we    = 1'b0;
    end
  end

  // Lock-mode sequencing and loader starvation counting.
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    case (state_r)
      ST_SHARED: begin
        if (bus.dbg_lock) begin
          state_nxt_s  = ST_DRAIN;
          starve_nxt_s = 8'd0;
        end else if (bus.dbg_req && !dbg_gnt_s) begin
          if (starve_r < LIMIT_C) begin
            starve_nxt_s = starve_r + 8'd1;
          end else begin
            starve_nxt_s = LIMIT_C;
          end
        end else begin
          starve_nxt_s = 8'd0;
        end
      end
      ST_DRAIN: begin
        // One dead cycle lets a read granted before the lock retire its rvalid.
        state_nxt_s  = ST_LOCKED;
        starve_nxt_s = 8'd0;
      end
      ST_LOCKED: begin
        if (!bus.dbg_lock) begin
          state_nxt_s = ST_SHARED;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
        starve_nxt_s = 8'd0;
      end
      default: begin
        state_nxt_s  = ST_SHARED;
        starve_nxt_s = 8'd0;
      end
    endcase
  end

  // State, starvation counter and read-return strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_SHARED;
      starve_r      <= 8'd0;
      core_rvalid_r <= 1'b0;
      dbg_rvalid_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      starve_r      <= starve_nxt_s;
      core_rvalid_r <= core_gnt_s & ~bus.core_we;
      dbg_rvalid_r  <= dbg_gnt_s & ~bus.dbg_we;
    end
  end

  assign bus.core_gnt    = core_gnt_s;
  assign bus.dbg_gnt     = dbg_gnt_s;
  assign bus.core_stall  = bus.core_req & ~core_gnt_s;
  assign bus.core_rvalid = core_rvalid_r;
  assign bus.dbg_rvalid  = dbg_rvalid_r;
  assign bus.dbg_owned   = (state_r == ST_LOCKED);
  assign bus.rdata       = bus.mem_rdata;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed plus randomized bench for tcm_port_arbiter against a cycle-level reference model
// and a behavioural single-port memory with one-cycle read latency.
module tb_tcm_port_arbiter;
  localparam int ADDR_W = 12;
  localparam int LIMIT  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcm_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  tcm_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ 32'(i * 7);
  endfunction

  // Behavioural memory: unwritten words read back a fixed address-derived pattern.
  logic [31:0]  mem [4096];
  bit   [4095:0] mem_wr;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_word(int'(bus.mem_addr));
  end

  // Reference model
  logic [31:0] ref_mem [4096];
  bit          m_drain, m_locked;
  int          m_wait;
  bit          m_core_rv, m_dbg_rv;
  logic [31:0] m_rdata;
  bit          e_core_gnt, e_dbg_gnt;
  bit          last_core_gnt, last_dbg_gnt, last_core_rv, last_dbg_rv, last_stall, last_owned;
  logic [31:0] last_rdata;
  logic [9:0]  core_hist, dbg_hist;
  bit          dbg_pending;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic model_reset();
    m_drain = 1'b0; m_locked = 1'b0; m_wait = 0;
    m_core_rv = 1'b0; m_dbg_rv = 1'b0;
  endtask

  task automatic predict();
    e_core_gnt = 1'b0;
    e_dbg_gnt  = 1'b0;
    if (m_locked) e_dbg_gnt = bus.dbg_req;
    else if (!m_drain) begin
      if (bus.dbg_req && (!bus.core_req || m_wait >= LIMIT)) e_dbg_gnt = 1'b1;
      else e_core_gnt = bus.core_req;
    end
  endtask

  task automatic compare_outputs();
    logic        x_we;
    logic [31:0] x_addr, x_wdata;
    x_we = 1'b0; x_addr = 32'd0; x_wdata = 32'd0;
    if (e_core_gnt) begin
      x_we = bus.core_we; x_addr = {20'd0, bus.core_addr}; x_wdata = bus.core_wdata;
    end else if (e_dbg_gnt) begin
      x_we = bus.dbg_we; x_addr = {20'd0, bus.dbg_addr}; x_wdata = bus.dbg_wdata;
    end
    check1("core_gnt", bus.core_gnt, e_core_gnt);
    check1("dbg_gnt", bus.dbg_gnt, e_dbg_gnt);
    check1("core_stall", bus.core_stall, bus.core_req & ~e_core_gnt);
    check1("dbg_owned", bus.dbg_owned, m_locked);
    check1("core_rvalid", bus.core_rvalid, m_core_rv);
    check1("dbg_rvalid", bus.dbg_rvalid, m_dbg_rv);
    check1("mem_we", bus.mem_we, x_we);
    check("mem_addr", {20'd0, bus.mem_addr}, x_addr);
    check("mem_wdata", bus.mem_wdata, x_wdata);
    if (m_core_rv || m_dbg_rv) check("rdata", bus.rdata, m_rdata);
    last_core_gnt = bus.core_gnt;  last_dbg_gnt = bus.dbg_gnt;
    last_core_rv  = bus.core_rvalid; last_dbg_rv = bus.dbg_rvalid;
    last_stall    = bus.core_stall;  last_owned  = bus.dbg_owned;
    last_rdata    = bus.rdata;
  endtask

  task automatic advance();
    m_core_rv = e_core_gnt && !bus.core_we;
    m_dbg_rv  = e_dbg_gnt && !bus.dbg_we;
    if (e_core_gnt) begin
      if (bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
      else m_rdata = ref_mem[bus.core_addr];
    end
    if (e_dbg_gnt) begin
      if (bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
      else m_rdata = ref_mem[bus.dbg_addr];
    end
    if (m_drain) begin
      m_drain = 1'b0; m_locked = 1'b1;
    end else if (m_locked) begin
      if (!bus.dbg_lock) m_locked = 1'b0;
    end else if (bus.dbg_lock) begin
      m_drain = 1'b1; m_wait = 0;
    end else if (bus.dbg_req && !e_dbg_gnt) begin
      m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic cycle();
    predict();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic set_core(logic req, logic we, logic [ADDR_W-1:0] addr, logic [31:0] wd);
    bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wd;
  endtask

  task automatic set_dbg(logic req, logic we, logic [ADDR_W-1:0] addr, logic [31:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst = 1'b1;
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    set_dbg(1'b0, 1'b0, 12'h000, 32'd0);
    bus.dbg_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check1("rst_core_gnt", bus.core_gnt, 1'b0);
    check1("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    check1("rst_core_rvalid", bus.core_rvalid, 1'b0);
    check1("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    check1("rst_dbg_owned", bus.dbg_owned, 1'b0);
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    // Lone core read of 0x010
    set_core(1'b1, 1'b0, 12'h010, 32'd0);
    cycle();
    check1("t2_gnt", last_core_gnt, 1'b1);
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    cycle();
    check1("t2_rvalid", last_core_rv, 1'b1);
    check("t2_rdata", last_rdata, init_word(16));

    // Both requesting for 10 cycles: loader wins exactly once, on cycle 8
    set_core(1'b1, 1'b0, 12'h100, 32'd0);
    set_dbg(1'b1, 1'b0, 12'h200, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      core_hist[i] = last_core_gnt;
      dbg_hist[i]  = last_dbg_gnt;
      if (i == 8) check1("t3_stall_c8", last_stall, 1'b1);
    end
    check("t3_core_seq", {22'd0, core_hist}, 32'h0000_02FF);
    check("t3_dbg_seq", {22'd0, dbg_hist}, 32'h0000_0100);
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    set_dbg(1'b0, 1'b0, 12'h000, 32'd0);
    cycle();

    // Loader write then core read of the same word
    set_dbg(1'b1, 1'b1, 12'h3FF, 32'hDEAD_BEEF);
    cycle();
    set_dbg(1'b0, 1'b0, 12'h000, 32'd0);
    set_core(1'b1, 1'b0, 12'h3FF, 32'd0);
    cycle();
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    cycle();
    check("t4_rdata", last_rdata, 32'hDEAD_BEEF);

    // Lock entry with a core read in flight, drain, locked, release
    set_core(1'b1, 1'b0, 12'h020, 32'd0);
    cycle();
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    bus.dbg_lock = 1'b1;
    cycle();
    check1("t5_inflight_rv", last_core_rv, 1'b1);
    set_core(1'b1, 1'b0, 12'h021, 32'd0);
    set_dbg(1'b1, 1'b1, 12'h022, 32'h1234_5678);
    cycle();
    check1("t5_drain_core", last_core_gnt, 1'b0);
    check1("t5_drain_dbg", last_dbg_gnt, 1'b0);
    cycle();
    check1("t5_lock_dbg", last_dbg_gnt, 1'b1);
    check1("t5_lock_stall", last_stall, 1'b1);
    check1("t5_lock_owned", last_owned, 1'b1);
    bus.dbg_lock = 1'b0;
    set_dbg(1'b1, 1'b0, 12'h022, 32'd0);
    cycle();
    check1("t5_exit_dbg", last_dbg_gnt, 1'b1);
    set_dbg(1'b0, 1'b0, 12'h000, 32'd0);
    cycle();
    check1("t5_after_core", last_core_gnt, 1'b1);
    check1("t5_after_owned", last_owned, 1'b0);
    set_core(1'b0, 1'b0, 12'h000, 32'd0);
    cycle();

    // Reset with a loader read return pending
    set_dbg(1'b1, 1'b0, 12'h022, 32'd0);
    cycle();
    set_dbg(1'b0, 1'b0, 12'h000, 32'd0);
    check1("t6_pending", bus.dbg_rvalid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check1("t6_rv_dropped", bus.dbg_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    check1("t6_owned", last_owned, 1'b0);

    // Randomized traffic; loader holds its request until granted
    dbg_pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      set_core(($urandom % 3) != 0, $urandom_range(0, 1) == 1,
               12'($urandom_range(0, 15)), $urandom);
      if (!dbg_pending) begin
        set_dbg(($urandom % 2) == 1, $urandom_range(0, 1) == 1,
                12'($urandom_range(0, 15)), $urandom);
      end
      if (($urandom % 16) == 0) bus.dbg_lock = ~bus.dbg_lock;
      cycle();
      dbg_pending = bus.dbg_req && !e_dbg_gnt;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
